// File: rtl/axi_regfile_if.sv
// axi_regfile_if: AXI4-Lite signal bundle between the PS interconnect and the
// register file. The slave modport is the register-file side, the master
// modport is the driving side.
interface axi_regfile_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [2:0]            s_axi_awprot;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic [STRB_W-1:0]     s_axi_wstrb;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [2:0]            s_axi_arprot;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output s_axi_rready
  );
endinterface

// File: rtl/axi_regfile.sv
// axi_regfile: AXI4-Lite slave with NUM_REGS byte-strobed read/write registers,
// presented to fabric logic as a flat reg_q bus. AW and W may arrive in either
// order; out-of-range accesses answer SLVERR and touch nothing.
// Optional feature macro: AXI_REGFILE_WR_PULSE_EN adds the reg_wr_pulse port,
// a one-cycle strobe per register after each committed in-range write.
module axi_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 8
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_aresetn,
  axi_regfile_if.slave                   s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
`ifdef AXI_REGFILE_WR_PULSE_EN
  ,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
`endif
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [IDX_W:0] NUM_REGS_V  = (IDX_W + 1)'(NUM_REGS);
  localparam logic [1:0]     RESP_OKAY   = 2'b00;
  localparam logic [1:0]     RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    WR_INIT      = 3'd0,
    WR_IDLE      = 3'd1,
    WR_WAIT_DATA = 3'd2,
    WR_WAIT_ADDR = 3'd3,
    WR_RESP      = 3'd4
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_INIT = 2'd0,
    RD_IDLE = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  // Register storage
  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

  // Write channel
  wr_state_e             wr_state_r, wr_next_s;
  logic                  awready_r, wready_r, bvalid_r;
  logic [1:0]            bresp_r;
  logic [IDX_W-1:0]      aw_idx_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_W-1:0]     wstrb_r;
  logic                  aw_hs_s, w_hs_s, wr_commit_s, wr_in_range_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [STRB_W-1:0]     wr_strb_s;

  // Read channel
  rd_state_e             rd_state_r, rd_next_s;
  logic                  arready_r, rvalid_r;
  logic [1:0]            rresp_r;
  logic [DATA_WIDTH-1:0] rdata_r, rd_mux_s;
  logic                  ar_hs_s, rd_in_range_s;
  logic [IDX_W-1:0]      rd_idx_s;

  // Protection bits and sub-word address bits carry no meaning here
  logic unused_s;
  assign unused_s = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot,
                      s_axi.s_axi_awaddr[ADDR_LSB-1:0], s_axi.s_axi_araddr[ADDR_LSB-1:0]};

  assign aw_hs_s = s_axi.s_axi_awvalid & awready_r;
  assign w_hs_s  = s_axi.s_axi_wvalid  & wready_r;
  assign ar_hs_s = s_axi.s_axi_arvalid & arready_r;

  assign s_axi.s_axi_awready = awready_r;
  assign s_axi.s_axi_wready  = wready_r;
  assign s_axi.s_axi_bvalid  = bvalid_r;
  assign s_axi.s_axi_bresp   = bresp_r;
  assign s_axi.s_axi_arready = arready_r;
  assign s_axi.s_axi_rvalid  = rvalid_r;
  assign s_axi.s_axi_rdata   = rdata_r;
  assign s_axi.s_axi_rresp   = rresp_r;

  // Pick the commit operands: latched copies for the half that arrived earlier
  always_comb begin
    wr_idx_s  = s_axi.s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
    wr_data_s = s_axi.s_axi_wdata;
    wr_strb_s = s_axi.s_axi_wstrb;
    if (wr_state_r == WR_WAIT_DATA) begin
      wr_idx_s = aw_idx_r;
    end else if (wr_state_r == WR_WAIT_ADDR) begin
      wr_data_s = wdata_r;
      wr_strb_s = wstrb_r;
    end else begin
      wr_idx_s = s_axi.s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
    end
    wr_in_range_s = ({1'b0, wr_idx_s} < NUM_REGS_V);
  end

  // Write FSM next state and commit strobe
  always_comb begin
    wr_next_s   = wr_state_r;
    wr_commit_s = 1'b0;
    case (wr_state_r)
      WR_INIT: wr_next_s = WR_IDLE;
      WR_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          wr_commit_s = 1'b1;
          wr_next_s   = WR_RESP;
        end else if (aw_hs_s) begin
          wr_next_s = WR_WAIT_DATA;
        end else if (w_hs_s) begin
          wr_next_s = WR_WAIT_ADDR;
        end else begin
          wr_next_s = WR_IDLE;
        end
      end
      WR_WAIT_DATA: begin
        if (w_hs_s) begin
          wr_commit_s = 1'b1;
          wr_next_s   = WR_RESP;
        end else begin
          wr_next_s = WR_WAIT_DATA;
        end
      end
      WR_WAIT_ADDR: begin
        if (aw_hs_s) begin
          wr_commit_s = 1'b1;
          wr_next_s   = WR_RESP;
        end else begin
          wr_next_s = WR_WAIT_ADDR;
        end
      end
      WR_RESP: begin
        if (s_axi.s_axi_bready) begin
          wr_next_s = WR_IDLE;
        end else begin
          wr_next_s = WR_RESP;
        end
      end
      default: wr_next_s = WR_INIT;
    endcase
  end

  // Write FSM state, readies derived from next state, response and half-transaction latches
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_state_r <= WR_INIT;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      aw_idx_r   <= '0;
      wdata_r    <= '0;
      wstrb_r    <= '0;
    end else begin
      wr_state_r <= wr_next_s;
      awready_r  <= (wr_next_s == WR_IDLE) || (wr_next_s == WR_WAIT_ADDR);
      wready_r   <= (wr_next_s == WR_IDLE) || (wr_next_s == WR_WAIT_DATA);
      bvalid_r   <= (wr_next_s == WR_RESP);
      if (wr_commit_s) begin
        bresp_r <= wr_in_range_s ? RESP_OKAY : RESP_SLVERR;
      end else if (wr_next_s != WR_RESP) begin
        bresp_r <= RESP_OKAY;
      end
      if (aw_hs_s) begin
        aw_idx_r <= s_axi.s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs_s) begin
        wdata_r <= s_axi.s_axi_wdata;
        wstrb_r <= s_axi.s_axi_wstrb;
      end
    end
  end

  // Register array: byte-strobed update on the commit edge; out-of-range index matches nothing
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_commit_s && (wr_idx_s == IDX_W'(i))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb_s[b]) begin
              regs_r[i][b*8 +: 8] <= wr_data_s[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
  end

`ifdef AXI_REGFILE_WR_PULSE_EN
  logic [NUM_REGS-1:0] wr_pulse_r;
  assign reg_wr_pulse = wr_pulse_r;

  // One-cycle strobe for the register that a commit just updated
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_pulse_r <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_pulse_r[i] <= wr_commit_s && (wr_idx_s == IDX_W'(i));
      end
    end
  end
`endif

  assign rd_idx_s      = s_axi.s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign rd_in_range_s = ({1'b0, rd_idx_s} < NUM_REGS_V);

  // Read data mux, zero when the index selects no register
  always_comb begin
    rd_mux_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_mux_s = rd_mux_s | (regs_r[i] & {DATA_WIDTH{rd_idx_s == IDX_W'(i)}});
    end
  end

  // Read FSM next state
  always_comb begin
    rd_next_s = rd_state_r;
    case (rd_state_r)
      RD_INIT: rd_next_s = RD_IDLE;
      RD_IDLE: begin
        if (ar_hs_s) begin
          rd_next_s = RD_DATA;
        end else begin
          rd_next_s = RD_IDLE;
        end
      end
      RD_DATA: begin
        if (s_axi.s_axi_rready) begin
          rd_next_s = RD_IDLE;
        end else begin
          rd_next_s = RD_DATA;
        end
      end
      default: rd_next_s = RD_INIT;
    endcase
  end

  // Read FSM state and registered R channel; capture uses pre-commit register values
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_state_r <= RD_INIT;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= '0;
      rresp_r    <= RESP_OKAY;
    end else begin
      rd_state_r <= rd_next_s;
      arready_r  <= (rd_next_s == RD_IDLE);
      rvalid_r   <= (rd_next_s == RD_DATA);
      if (ar_hs_s) begin
        rdata_r <= rd_in_range_s ? rd_mux_s : '0;
        rresp_r <= rd_in_range_s ? RESP_OKAY : RESP_SLVERR;
      end else if ((rd_state_r == RD_DATA) && s_axi.s_axi_rready) begin
        rdata_r <= '0;
        rresp_r <= RESP_OKAY;
      end
    end
  end
endmodule

// File: tb/tb_axi_regfile.sv
// tb_axi_regfile: randomized self-checking bench for axi_regfile against an
// array-based register model. Reg_wr_pulse checks are built when
// AXI_REGFILE_WR_PULSE_EN is defined.
`timescale 1ns/1ps
module tb_axi_regfile;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 8;
  localparam int SW = DW / 8;
  localparam int LSB = 2;
  localparam int BUDGET = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic [NR*DW-1:0] reg_q;
`ifdef AXI_REGFILE_WR_PULSE_EN
  logic [NR-1:0] reg_wr_pulse;
`endif

  axi_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi         (bus),
    .reg_q         (reg_q)
`ifdef AXI_REGFILE_WR_PULSE_EN
    ,
    .reg_wr_pulse  (reg_wr_pulse)
`endif
  );

  int n_checks = 0;
  int n_fails  = 0;
  logic [DW-1:0] mdl [NR];

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NR*DW-1:0] mdl_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  task automatic mdl_write(input int idx, input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < SW; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    if (idx < NR) mdl[idx] = (mdl[idx] & ~m) | (d & m);
  endtask

  task automatic idle_inputs();
    bus.s_axi_awaddr = '0; bus.s_axi_awprot = 3'd0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b1;
    bus.s_axi_araddr = '0; bus.s_axi_arprot = 3'd0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val(tag, {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready, bus.s_axi_bvalid,
                    bus.s_axi_rvalid, bus.s_axi_bresp, bus.s_axi_rresp, bus.s_axi_rdata}, '0);
    check_val({tag, "_reg_q"}, reg_q, '0);
`ifdef AXI_REGFILE_WR_PULSE_EN
    check_val({tag, "_pulse"}, reg_wr_pulse, '0);
`endif
  endtask

  task automatic reset_sequence();
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_rel_ready0", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b000);
    @(posedge clk); #1;
    check_val("rst_rel_ready1", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b111);
  endtask

  // AW offered from cycle aw_dly, W from cycle w_dly; bready held low b_hold cycles
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input int aw_dly, input int w_dly,
                           input int b_hold);
    int idx, cyc;
    bit aw_pend, w_pend, aw_fire, w_fire, early_b;
    logic [1:0] exp_resp;
    idx = int'(addr) >> LSB;
    exp_resp = (idx < NR) ? 2'b00 : 2'b10;
    aw_pend = 1'b1; w_pend = 1'b1; early_b = 1'b0; cyc = 0;
    bus.s_axi_awaddr = addr; bus.s_axi_wdata = data; bus.s_axi_wstrb = strb;
    bus.s_axi_bready = (b_hold == 0);
    while ((aw_pend || w_pend) && cyc < BUDGET) begin
      bus.s_axi_awvalid = aw_pend && (cyc >= aw_dly);
      bus.s_axi_wvalid  = w_pend && (cyc >= w_dly);
      aw_fire = bus.s_axi_awvalid && bus.s_axi_awready;
      w_fire  = bus.s_axi_wvalid && bus.s_axi_wready;
      if (bus.s_axi_bvalid) early_b = 1'b1;
      @(posedge clk); #1;
      if (aw_fire) aw_pend = 1'b0;
      if (w_fire) w_pend = 1'b0;
      cyc++;
    end
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    check_val("wr_hs_timeout", {aw_pend, w_pend}, 2'b00);
    check_val("wr_early_bvalid", early_b, 1'b0);
    mdl_write(idx, data, strb);
    check_val("wr_reg_q", reg_q, mdl_flat());
    check_val("wr_bvalid_bresp", {bus.s_axi_bvalid, bus.s_axi_bresp}, {1'b1, exp_resp});
`ifdef AXI_REGFILE_WR_PULSE_EN
    check_val("wr_pulse", reg_wr_pulse, (idx < NR) ? (NR'(1) << idx) : NR'(0));
`endif
    for (int h = 0; h < b_hold; h++) begin
      bus.s_axi_awvalid = 1'b1;
      check_val("wr_b_hold", {bus.s_axi_bvalid, bus.s_axi_bresp, bus.s_axi_awready, bus.s_axi_wready},
                {1'b1, exp_resp, 2'b00});
      @(posedge clk); #1;
    end
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_bready = 1'b1;
    @(posedge clk); #1;
    check_val("wr_b_done", {bus.s_axi_bvalid, bus.s_axi_awready, bus.s_axi_wready}, 3'b011);
    check_val("wr_reg_q_after", reg_q, mdl_flat());
`ifdef AXI_REGFILE_WR_PULSE_EN
    check_val("wr_pulse_off", reg_wr_pulse, '0);
`endif
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int r_hold);
    int idx, cyc;
    logic [DW-1:0] exp_data;
    logic [1:0] exp_resp;
    idx = int'(addr) >> LSB;
    if (idx < NR) begin
      exp_data = mdl[idx]; exp_resp = 2'b00;
    end else begin
      exp_data = '0; exp_resp = 2'b10;
    end
    bus.s_axi_araddr = addr; bus.s_axi_arvalid = 1'b1;
    bus.s_axi_rready = (r_hold == 0);
    cyc = 0;
    while (!bus.s_axi_arready && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("rd_ar_timeout", bus.s_axi_arready, 1'b1);
    @(posedge clk); #1;
    bus.s_axi_arvalid = 1'b0;
    check_val("rd_data", {bus.s_axi_rvalid, bus.s_axi_rresp, bus.s_axi_rdata}, {1'b1, exp_resp, exp_data});
    for (int h = 0; h < r_hold; h++) begin
      bus.s_axi_arvalid = 1'b1;
      @(posedge clk); #1;
      check_val("rd_r_hold", {bus.s_axi_rvalid, bus.s_axi_rresp, bus.s_axi_rdata, bus.s_axi_arready},
                {1'b1, exp_resp, exp_data, 1'b0});
    end
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b1;
    @(posedge clk); #1;
    check_val("rd_r_done", {bus.s_axi_rvalid, bus.s_axi_rdata, bus.s_axi_arready}, {1'b0, 32'h0, 1'b1});
  endtask

  // Write and read the same register on one edge: read must see the old value
  task automatic same_edge(input int idx, input logic [DW-1:0] data);
    logic [DW-1:0] old;
    old = mdl[idx];
    bus.s_axi_awaddr = AW'(idx << LSB); bus.s_axi_wdata = data; bus.s_axi_wstrb = '1;
    bus.s_axi_araddr = AW'(idx << LSB);
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
    check_val("se_ready", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b111);
    @(posedge clk); #1;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    mdl_write(idx, data, '1);
    check_val("se_old_rdata", {bus.s_axi_rvalid, bus.s_axi_rdata}, {1'b1, old});
    check_val("se_reg_q", reg_q, mdl_flat());
    @(posedge clk); #1;
    check_val("se_done", {bus.s_axi_bvalid, bus.s_axi_rvalid}, 2'b00);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset_sequence();

    axi_write(6'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(6'h04, 0);
    check_val("deadbeef_slice", reg_q[63:32], 32'hDEADBEEF);

    axi_write(6'h08, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(6'h08, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    axi_read(6'h08, 0);
    check_val("strb_merge", reg_q[95:64], 32'h11BB33DD);

    axi_write(6'h0C, 32'h5, 4'hF, 3, 0, 0);
    check_val("w_first", reg_q[127:96], 32'h5);
    axi_write(6'h0C, 32'h0, 4'hF, 0, 0, 0);
    axi_write(6'h0C, 32'h5, 4'hF, 0, 3, 0);
    check_val("aw_first", reg_q[127:96], 32'h5);

    axi_write(6'h20, 32'h12345678, 4'hF, 0, 0, 0);
    axi_read(6'h3C, 0);
    axi_write(6'h3E, 32'hFFFFFFFF, 4'hF, 1, 0, 0);

    axi_write(6'h10, 32'hCAFEF00D, 4'hF, 0, 0, 5);
    axi_read(6'h10, 5);

    axi_write(6'h10, 32'h0BADC0DE, 4'h0, 0, 0, 0);
    check_val("strb_zero", reg_q[159:128], 32'hCAFEF00D);

    same_edge(1, 32'h600DF00D);
    axi_read(6'h07, 0);

    for (int n = 0; n < 40; n++) begin
      axi_write(AW'($urandom_range(0, 63)), $urandom, SW'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      axi_read(AW'($urandom_range(0, 63)), $urandom_range(0, 2));
    end

    bus.s_axi_awaddr = 6'h18; bus.s_axi_awvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_axi_awvalid = 1'b0;
    check_val("mid_wr_wait", {bus.s_axi_awready, bus.s_axi_wready}, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_wr_rst");
    reset_sequence();
    axi_write(6'h18, 32'hA5A5A5A5, 4'hF, 0, 2, 0);
    axi_read(6'h18, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/axi_regfile.md
# axi_regfile

Parametrised AXI4-Lite slave holding NUM_REGS read/write registers of DATA_WIDTH bits, exposed to fabric logic as a flat output bus. Successor to the single-register AXI-Lite slave in the TPU control path: it adds address decode, byte-strobe writes, independent AW/W arrival order and SLVERR on out-of-range accesses. Sits between the PS AXI interconnect and TPU control/config logic.

## Interface
- DATA_WIDTH, 32, data bus and register width; 32 or 64.
- ADDR_WIDTH, 6, AXI byte-address width; 2^(ADDR_WIDTH-ADDR_LSB) >= NUM_REGS required.
- NUM_REGS, 8, number of implemented registers, >= 1.
- Derived: ADDR_LSB = log2(DATA_WIDTH/8); STRB_W = DATA_WIDTH/8.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid  in  1 / s_axi_awready  out  1  write-address handshake.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  STRB_W  byte enables.
- s_axi_wvalid  in  1 / s_axi_wready  out  1  write-data handshake.
- s_axi_bresp  out  2  OKAY 2'b00 or SLVERR 2'b10.
- s_axi_bvalid  out  1 / s_axi_bready  in  1  write response.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid  in  1 / s_axi_arready  out  1  read-address handshake.
- s_axi_rdata  out  DATA_WIDTH / s_axi_rresp  out  2  read data and response.
- s_axi_rvalid  out  1 / s_axi_rready  in  1  read handshake.
- reg_q  out  NUM_REGS*DATA_WIDTH  register contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- reg_wr_pulse  out  NUM_REGS  per-register write pulse (only with AXI_REGFILE_WR_PULSE_EN).

## Operation
- Decode: index = addr[ADDR_WIDTH-1:ADDR_LSB]; addr[ADDR_LSB-1:0] ignored. index >= NUM_REGS is out of range.
- Write FSM: WR_INIT -> WR_IDLE (awready=wready=1). In WR_IDLE: AW and W in same cycle -> commit, WR_RESP; only AW -> latch addr, awready=0, WR_WAIT_DATA; only W -> latch data/strb, wready=0, WR_WAIT_ADDR. WR_WAIT_DATA/WR_WAIT_ADDR: on missing handshake -> commit, WR_RESP.
- Commit: for each byte b with wstrb[b]=1, reg[index] byte b <= wdata byte b; other bytes unchanged. wstrb=0 is a legal no-op, OKAY. Out-of-range: no register changes, bresp=SLVERR.
- WR_RESP: bvalid=1, awready=wready=0; on bready -> bvalid=0, awready=wready=1, WR_IDLE.
- Read FSM: RD_INIT -> RD_IDLE (arready=1). On arvalid: arready=0, rdata <= reg[index] (0 if out of range), rresp OKAY/SLVERR, rvalid=1, RD_DATA. RD_DATA: hold rdata/rresp stable until rready; then rvalid=0, rdata=0, arready=1, RD_IDLE.
- Read and write FSMs independent; both may handshake in the same cycle.

## Timing
- Reset (async): all registers 0, reg_q=0, awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, reg_wr_pulse=0. FSMs to *_INIT; readies go high one cycle after reset release.
- Register updates on the edge that completes both AW and W; reg_q reflects it the same edge; bvalid high the following cycle.
- Read latency: rvalid one cycle after AR handshake edge.
- Same-edge read capture and write commit to same register: read returns pre-write value.
- Peak throughput: one write per 2 cycles, one read per 2 cycles (bready/rready tied high).
- Reset mid-transaction: transaction dropped, no response issued, registers cleared.

## Configuration
- AXI_REGFILE_WR_PULSE_EN defined: reg_wr_pulse[i] high for exactly one cycle, the cycle after a committed in-range write to reg i (any wstrb, including 0), aligned with updated reg_q. Undefined: port and logic absent; all other behaviour identical.

## Test plan
- Reset release -> cycle 1 awready=wready=arready=1; write 0xDEADBEEF to 0x04, read 0x04 -> rdata 0xDEADBEEF, rresp 0, bresp 0, reg_q[63:32]=0xDEADBEEF.
- Reg 2 = 0x11223344, write 0xAABBCCDD wstrb 4'b0101 to 0x08 -> read 0x08 returns 0x11BB33DD.
- W valid 3 cycles before AW, then AW to 0x0C with 0x5 -> single bvalid after AW handshake, reg 3 = 5; repeat with AW first -> same result.
- Write 0x12345678 to 0x20 (index 8, NUM_REGS=8) -> bresp 2'b10, all reg_q unchanged; read 0x3C -> rresp 2'b10, rdata 0.
- Hold bready/rready low 5 cycles -> bvalid/rvalid, rdata stable, readies low; no second transaction accepted.
- With AXI_REGFILE_WR_PULSE_EN: write to 0x00 -> reg_wr_pulse=8'b00000001 for one cycle, no pulse for SLVERR write; assert reset mid-write -> all outputs return to reset values.
